// File: rtl/traffic_intersection_ctrl.sv
// Two-road signal controller: main/side lamps, pedestrian walk request and
// night-mode flashing yellow, phases timed in seconds from a prescaled tick.
module traffic_intersection_ctrl #(
  parameter int unsigned TICK_DIV   = 27_000_000,
  parameter int unsigned GRN_MAIN_S = 10,
  parameter int unsigned GRN_SIDE_S = 5,
  parameter int unsigned YEL_S      = 2,
  parameter int unsigned ALLRED_S   = 1,
  parameter int unsigned MIN_GRN_S  = 3
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       ped_btn_n,
  input  logic       night_mode,
  output logic [2:0] led_main,
  output logic [2:0] led_side,
  output logic       walk_n,
  output logic       ped_pending,
  output logic [2:0] state_o
);

  localparam int unsigned TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  localparam logic [7:0] GRN_MAIN_LAST = 8'(GRN_MAIN_S - 1);
  localparam logic [7:0] GRN_SIDE_LAST = 8'(GRN_SIDE_S - 1);
  localparam logic [7:0] YEL_LAST      = 8'(YEL_S - 1);
  localparam logic [7:0] ALLRED_LAST   = 8'(ALLRED_S - 1);
  localparam logic [7:0] MIN_GRN_LAST  = 8'(MIN_GRN_S - 1);

  localparam logic [2:0] LAMP_RED = 3'b011;
  localparam logic [2:0] LAMP_YEL = 3'b101;
  localparam logic [2:0] LAMP_GRN = 3'b110;
  localparam logic [2:0] LAMP_OFF = 3'b111;

  typedef enum logic [2:0] {
    RED_TO_MAIN = 3'd0,
    MAIN_GRN    = 3'd1,
    MAIN_YEL    = 3'd2,
    RED_TO_SIDE = 3'd3,
    SIDE_GRN    = 3'd4,
    SIDE_YEL    = 3'd5,
    FLASH       = 3'd6
  } state_t;

  state_t           state_reg, state_next;
  logic [TCW-1:0]   tick_cnt_reg;
  logic [7:0]       sec_cnt_reg;
  logic             flash_ph_reg;
  logic             ped_pending_reg;
  logic [2:0]       ped_sync_reg;
  logic [1:0]       night_sync_reg;

  logic tick, night, press, state_change, enter_side_grn, enter_flash;

  assign tick  = (tick_cnt_reg == TCW'(TICK_DIV - 1));
  assign night = night_sync_reg[1];
  // Falling edge of the synchronized button: one request per press
  assign press = ped_sync_reg[2] & ~ped_sync_reg[1];

  assign state_change   = (state_next != state_reg);
  assign enter_side_grn = state_change && (state_next == SIDE_GRN);
  assign enter_flash    = state_change && (state_next == FLASH);

  always_comb begin
    state_next = state_reg;
    led_main   = LAMP_RED;
    led_side   = LAMP_RED;
    walk_n     = 1'b1;
    case (state_reg)
      RED_TO_MAIN: begin
        if (tick && sec_cnt_reg == ALLRED_LAST)
          state_next = night ? FLASH : MAIN_GRN;
      end
      MAIN_GRN: begin
        led_main = LAMP_GRN;
        if (tick && (sec_cnt_reg == GRN_MAIN_LAST ||
                     (ped_pending_reg && sec_cnt_reg >= MIN_GRN_LAST)))
          state_next = MAIN_YEL;
      end
      MAIN_YEL: begin
        led_main = LAMP_YEL;
        if (tick && sec_cnt_reg == YEL_LAST)
          state_next = RED_TO_SIDE;
      end
      RED_TO_SIDE: begin
        if (tick && sec_cnt_reg == ALLRED_LAST)
          state_next = night ? FLASH : SIDE_GRN;
      end
      SIDE_GRN: begin
        led_side = LAMP_GRN;
        walk_n   = 1'b0;
        if (tick && sec_cnt_reg == GRN_SIDE_LAST)
          state_next = SIDE_YEL;
      end
      SIDE_YEL: begin
        led_side = LAMP_YEL;
        if (tick && sec_cnt_reg == YEL_LAST)
          state_next = RED_TO_MAIN;
      end
      FLASH: begin
        led_main = flash_ph_reg ? LAMP_OFF : LAMP_YEL;
        led_side = flash_ph_reg ? LAMP_OFF : LAMP_YEL;
        if (tick && !night)
          state_next = RED_TO_MAIN;
      end
      default: state_next = RED_TO_MAIN;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg       <= RED_TO_MAIN;
      tick_cnt_reg    <= '0;
      sec_cnt_reg     <= '0;
      flash_ph_reg    <= 1'b0;
      ped_pending_reg <= 1'b0;
      ped_sync_reg    <= 3'b111;
      night_sync_reg  <= 2'b00;
    end else begin
      ped_sync_reg   <= {ped_sync_reg[1:0], ped_btn_n};
      night_sync_reg <= {night_sync_reg[0], night_mode};
      state_reg      <= state_next;

      // Counters restart on every phase change so each phase is exactly D seconds
      if (state_change) begin
        tick_cnt_reg <= '0;
        sec_cnt_reg  <= '0;
      end else if (tick) begin
        tick_cnt_reg <= '0;
        sec_cnt_reg  <= sec_cnt_reg + 8'd1;
      end else begin
        tick_cnt_reg <= tick_cnt_reg + 1'b1;
      end

      if (enter_flash)
        flash_ph_reg <= 1'b0;
      else if (state_reg == FLASH && tick)
        flash_ph_reg <= ~flash_ph_reg;

      if (enter_side_grn || enter_flash)
        ped_pending_reg <= 1'b0;
      else if (press && state_reg != SIDE_GRN && state_reg != FLASH)
        ped_pending_reg <= 1'b1;
    end
  end

  assign ped_pending = ped_pending_reg;
  assign state_o     = state_reg;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Directed bench: expected lamp/state events are queued by the stimulus and
// checked by a monitor that pops one entry per observed output change.
module tb_traffic_intersection_ctrl;

  localparam logic [2:0] R = 3'b011;
  localparam logic [2:0] Y = 3'b101;
  localparam logic [2:0] G = 3'b110;
  localparam logic [2:0] O = 3'b111;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b1;
  logic       ped_btn_n = 1'b1;
  logic       night_mode = 1'b0;
  logic [2:0] led_main, led_side, state_o;
  logic       walk_n, ped_pending;
  bit         mon_en = 1'b0;

  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [2:0]  lm;
    logic [2:0]  ls;
    logic        wk;
    logic [15:0] cyc;
  } ev_t;

  ev_t exp_q[$];

  traffic_intersection_ctrl #(
    .TICK_DIV(4), .GRN_MAIN_S(6), .GRN_SIDE_S(4),
    .YEL_S(2), .ALLRED_S(1), .MIN_GRN_S(2)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .ped_btn_n(ped_btn_n),
    .night_mode(night_mode), .led_main(led_main), .led_side(led_side),
    .walk_n(walk_n), .ped_pending(ped_pending), .state_o(state_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic push(input logic [2:0] st, input logic [2:0] lm,
                      input logic [2:0] ls, input logic wk, input int cyc);
    ev_t e;
    e.st = st; e.lm = lm; e.ls = ls; e.wk = wk; e.cyc = 16'(cyc);
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end else begin
      $display("ok   %s: %0h at %0t", name, act, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Returns 1 time unit after the clock edge on which state s is entered
  task automatic wait_entry(input logic [2:0] s, input int budget);
    logic [2:0] prev_s;
    bit hit;
    prev_s = state_o;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      @(posedge sys_clk);
      #1;
      if (state_o == s && prev_s != s) hit = 1'b1;
      prev_s = state_o;
    end
    if (!hit) begin
      total++;
      bad++;
      $display("FAIL wait_state%0d: state=%0d, not entered within %0d cycles", s, state_o, budget);
    end
  endtask

  initial begin : monitor
    logic [9:0] prev, cur;
    int cnt;
    ev_t e;
    wait (mon_en);
    @(negedge sys_clk);
    prev = {state_o, led_main, led_side, walk_n};
    cnt = 0;
    forever begin
      @(negedge sys_clk);
      cnt++;
      cur = {state_o, led_main, led_side, walk_n};
      if (cur !== prev) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL event: unexpected change to st=%0d main=%b side=%b walk_n=%b after %0d cycles",
                   state_o, led_main, led_side, walk_n, cnt);
        end else begin
          e = exp_q.pop_front();
          if (cur !== {e.st, e.lm, e.ls, e.wk} || cnt != int'(e.cyc)) begin
            bad++;
            $display("FAIL event: got st=%0d main=%b side=%b walk_n=%b after %0d cycles, expected st=%0d main=%b side=%b walk_n=%b after %0d",
                     state_o, led_main, led_side, walk_n, cnt, e.st, e.lm, e.ls, e.wk, e.cyc);
          end else begin
            $display("ok   event: st=%0d main=%b side=%b walk_n=%b after %0d cycles",
                     state_o, led_main, led_side, walk_n, cnt);
          end
        end
        prev = cur;
        cnt = 0;
      end
      if (!sys_rst_n) cnt = 0;
    end
  end

  initial begin : stimulus
    #1 sys_rst_n = 1'b0;
    mon_en = 1'b1;
    #2;
    check("reset_state", 16'(state_o), 16'd0);
    check("reset_lamps", {10'd0, led_main, led_side}, {10'd0, R, R});
    check("reset_walk_pend", {14'd0, walk_n, ped_pending}, 16'b10);
    #9 sys_rst_n = 1'b1;

    // Free-running sequence, one full period plus the next main green
    push(1, G, R, 1, 4);  push(2, Y, R, 1, 24); push(3, R, R, 1, 8);
    push(4, R, G, 0, 4);  push(5, R, Y, 1, 16); push(0, R, R, 1, 8);
    push(1, G, R, 1, 4);
    wait_entry(0, 100);
    wait_entry(1, 100);

    // Press in the first cycle of main green: 8-cycle green, walk for whole side green
    push(2, Y, R, 1, 8);  push(3, R, R, 1, 8);  push(4, R, G, 0, 4);
    push(5, R, Y, 1, 16); push(0, R, R, 1, 8);  push(1, G, R, 1, 4);
    ped_btn_n = 1'b0;
    cyc(3);
    check("pend_set_early", 16'(ped_pending), 16'd1);
    cyc(2);
    ped_btn_n = 1'b1;
    wait_entry(4, 100);
    check("pend_clr_side", 16'(ped_pending), 16'd0);
    wait_entry(1, 100);

    // Press at second 4 of main green, then a press ignored in side green
    push(2, Y, R, 1, 20); push(3, R, R, 1, 8);  push(4, R, G, 0, 4);
    push(5, R, Y, 1, 16); push(0, R, R, 1, 8);  push(1, G, R, 1, 4);
    cyc(16);
    ped_btn_n = 1'b0;
    cyc(3);
    check("pend_set_late", 16'(ped_pending), 16'd1);
    cyc(2);
    ped_btn_n = 1'b1;
    wait_entry(4, 100);
    cyc(3);
    ped_btn_n = 1'b0;
    cyc(5);
    ped_btn_n = 1'b1;
    cyc(4);
    check("pend_ignored_side", 16'(ped_pending), 16'd0);
    wait_entry(1, 100);

    // Night mode requested in main green: finishes to all-red, then flashes
    night_mode = 1'b1;
    push(2, Y, R, 1, 24); push(3, R, R, 1, 8);  push(6, Y, Y, 1, 4);
    push(6, O, O, 1, 4);  push(6, Y, Y, 1, 4);  push(0, R, R, 1, 4);
    push(1, G, R, 1, 4);
    wait_entry(6, 100);
    cyc(9);
    night_mode = 1'b0;
    wait_entry(1, 100);

    // Button held for 100 cycles: only the first main green is cut short
    push(2, Y, R, 1, 8);  push(3, R, R, 1, 8);  push(4, R, G, 0, 4);
    push(5, R, Y, 1, 16); push(0, R, R, 1, 8);  push(1, G, R, 1, 4);
    push(2, Y, R, 1, 24); push(3, R, R, 1, 8);  push(4, R, G, 0, 4);
    push(5, R, Y, 1, 16); push(0, R, R, 1, 8);  push(1, G, R, 1, 4);
    ped_btn_n = 1'b0;
    cyc(100);
    ped_btn_n = 1'b1;
    wait_entry(1, 100);

    // Reset pulse in the middle of side yellow with a request latched
    push(2, Y, R, 1, 24); push(3, R, R, 1, 8);  push(4, R, G, 0, 4);
    push(5, R, Y, 1, 16); push(0, R, R, 1, 4);  push(1, G, R, 1, 4);
    wait_entry(5, 100);
    ped_btn_n = 1'b0;
    cyc(3);
    check("pend_set_yel", 16'(ped_pending), 16'd1);
    cyc(1);
    sys_rst_n = 1'b0;
    #1;
    check("rst_mid_lamps", {10'd0, led_main, led_side}, {10'd0, R, R});
    check("rst_mid_walk_pend", {14'd0, walk_n, ped_pending}, 16'b10);
    check("rst_mid_state", 16'(state_o), 16'd0);
    #8 ped_btn_n = 1'b1;
    #7 sys_rst_n = 1'b1;
    wait_entry(1, 20);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge sys_clk);
    cyc(2);
    check("queue_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
